// File: rtl/midi_uart_tx.sv
// rtl/midi_uart_tx.sv - MIDI 8N1 serial transmitter with a small transmit FIFO
//
// Bytes offered on data_in/data_valid are accepted whenever data_ready is high.
// They are queued in a circular FIFO and sent as 8N1 frames (start bit,
// 8 data bits LSB first, stop bit), with every bit lasting DIV clocks.
// A new frame follows a stop bit immediately when more bytes are queued.
//
// Parameters:
//   CLK_FREQ_HZ - system clock frequency in Hz
//   BAUD_RATE   - serial bit rate (31250 for MIDI)
//   FIFO_DEPTH  - transmit FIFO depth in bytes (power of 2, >= 2)
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   data_in    - byte to send, sampled on accept
//   data_valid - data_in is valid
//   data_ready - FIFO can accept a byte (combinational !full)
//   tx         - registered serial output, idles high
//   busy       - frame in progress or FIFO non-empty
//   fifo_level - number of queued bytes, 0..FIFO_DEPTH

module midi_uart_tx #(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BAUD_RATE   = 31_250,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [7:0]       fifo_head;

    assign fifo_empty = (level == '0);
    assign data_ready = (level != LVL_FULL);
    assign push       = data_valid && data_ready;
    assign fifo_head  = fifo_mem[rd_ptr];
    assign fifo_level = level;

    // Storage carries no reset; only the pointers and level define content.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_next;
    logic             tx_reg;
    logic             tx_next;
    logic             bit_end;

    assign bit_end = (baud_cnt == CNT_LAST);
    assign tx      = tx_reg;
    assign busy    = (state != S_IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    // tx_next is the level the line takes on the coming edge, so the line
    // changes on the same edge as the state transition that defines it.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt + 1'b1;
        bit_idx_next  = bit_idx;
        shift_next    = shift_reg;
        tx_next       = tx_reg;
        pop           = 1'b0;

        case (state)
            S_IDLE: begin
                tx_next       = 1'b1;
                baud_cnt_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    tx_next    = 1'b0;
                    state_next = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    tx_next       = shift_reg[0];
                    shift_next    = {1'b0, shift_reg[7:1]};
                    state_next    = S_DATA;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        tx_next      = shift_reg[0];
                        shift_next   = {1'b0, shift_reg[7:1]};
                    end
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    // Back-to-back: the next start bit begins right after
                    // the stop bit, with no idle clock in between.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        tx_next    = 1'b0;
                        state_next = S_START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end

            default: begin
                tx_next       = 1'b1;
                baud_cnt_next = '0;
                state_next    = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_midi_uart_tx.sv
// tb/tb_midi_uart_tx.sv - directed self-checking bench for midi_uart_tx
module tb_midi_uart_tx;

    localparam int DIV   = 320;
    localparam int FRAME = 3200;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;

    int checks;
    int failures;
    int cyc;

    midi_uart_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: samples tx every clock of a frame, decodes mid-bit and
    // verifies every bit is constant over its DIV clocks.
    logic [7:0] rx_q[$];
    int         start_q[$];
    bit         ok_q[$];
    logic [7:0] mon_b;
    bit         mon_ok;
    bit         mon_abort;
    logic       mon_first;
    int         mon_start;

    initial begin : rx_monitor
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                mon_start = cyc;
                mon_ok    = 1'b1;
                mon_abort = 1'b0;
                mon_b     = 8'h00;
                mon_first = 1'b0;
                for (int off = 0; off < FRAME; off++) begin
                    if (off > 0) @(negedge clk);
                    if (!rst_n) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    if (off % DIV == 0) mon_first = tx;
                    else if (tx !== mon_first) mon_ok = 1'b0;
                    if (off < DIV && tx !== 1'b0) mon_ok = 1'b0;
                    if (off >= 9 * DIV && tx !== 1'b1) mon_ok = 1'b0;
                    if ((off % DIV == DIV / 2) && (off / DIV >= 1) && (off / DIV <= 8))
                        mon_b[off / DIV - 1] = tx;
                end
                if (!mon_abort) begin
                    rx_q.push_back(mon_b);
                    start_q.push_back(mon_start);
                    ok_q.push_back(mon_ok);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers a byte and returns at the negedge after the accepting edge.
    task automatic push_one(input logic [7:0] b, output int acc);
        bit done;
        done = 1'b0;
        acc = -1;
        data_in = b;
        data_valid = 1'b1;
        for (int i = 0; i < 8000 && !done; i++) begin
            if (data_ready) done = 1'b1;
            @(negedge clk);
        end
        data_valid = 1'b0;
        if (done) acc = cyc;
        else check("push_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_busy_low(output int t);
        t = -1;
        for (int i = 0; i < 25000; i++) begin
            @(negedge clk);
            if (!busy) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 25000 && rx_q.size() < n; i++) @(negedge clk);
        check("rx_count", 32'(rx_q.size()), 32'(n));
    endtask

    int acc;
    int acc2;
    int t_busy;
    int base;
    int accs[6];
    int n;
    bit will;
    int bad_tx;
    int bad_busy;
    int bad_lvl;
    logic [7:0] seq[6];

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        data_in = 8'h00;
        data_valid = 1'b1;
        seq[0] = 8'h90; seq[1] = 8'h40; seq[2] = 8'h7F;
        seq[3] = 8'hB0; seq[4] = 8'h64; seq[5] = 8'h00;

        // Reset state, with data_valid held to show accepts are blocked
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(data_ready), 32'd1);
        data_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0x90
        base = rx_q.size();
        push_one(8'h90, acc);
        check("single_level", 32'(fifo_level), 32'd1);
        check("single_tx_before", 32'(tx), 32'd1);
        wait_busy_low(t_busy);
        wait_rx(base + 1);
        if (rx_q.size() > base) begin
            check("single_data", 32'(rx_q[base]), 32'h90);
            check("single_frame_ok", 32'(ok_q[base]), 32'd1);
            check("single_latency", 32'(start_q[base] - acc), 32'd1);
            check("single_busy_len", 32'(t_busy - start_q[base]), 32'(FRAME));
        end

        // Six bytes with data_valid held
        base = rx_q.size();
        n = 0;
        data_in = seq[0];
        data_valid = 1'b1;
        for (int i = 0; i < 8000 && n < 6; i++) begin
            will = data_ready;
            @(negedge clk);
            if (will) begin
                accs[n] = cyc;
                n++;
                if (n < 6) data_in = seq[n];
                else data_valid = 1'b0;
                if (n == 5) begin
                    check("burst_full_level", 32'(fifo_level), 32'd4);
                    check("burst_ready_low", 32'(data_ready), 32'd0);
                end
            end
        end
        data_valid = 1'b0;
        check("burst_accepts", 32'(n), 32'd6);
        if (n == 6) begin
            check("burst_consecutive", 32'(accs[4] - accs[0]), 32'd4);
            check("burst_reaccept", 32'(accs[5] - accs[0]), 32'(FRAME + 2));
        end
        wait_rx(base + 6);
        if (rx_q.size() >= base + 6) begin
            for (int k = 0; k < 6; k++) begin
                check($sformatf("burst_data%0d", k), 32'(rx_q[base + k]), 32'(seq[k]));
                check($sformatf("burst_ok%0d", k), 32'(ok_q[base + k]), 32'd1);
                if (k > 0)
                    check($sformatf("burst_spacing%0d", k),
                          32'(start_q[base + k] - start_q[base + k - 1]), 32'(FRAME));
            end
            check("burst_latency", 32'(start_q[base] - accs[0]), 32'd1);
        end
        wait_busy_low(t_busy);

        // Idle for 20 bit periods
        base = rx_q.size();
        bad_tx = 0; bad_busy = 0; bad_lvl = 0;
        for (int i = 0; i < 20 * DIV; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
            if (fifo_level !== 3'd0) bad_lvl++;
        end
        check("idle_tx", 32'(bad_tx), 32'd0);
        check("idle_busy", 32'(bad_busy), 32'd0);
        check("idle_level", 32'(bad_lvl), 32'd0);
        check("idle_no_frames", 32'(rx_q.size()), 32'(base));

        // 0x55 then 0xAA
        base = rx_q.size();
        push_one(8'h55, acc);
        push_one(8'hAA, acc2);
        wait_rx(base + 2);
        if (rx_q.size() >= base + 2) begin
            check("pat55_data", 32'(rx_q[base]), 32'h55);
            check("pat55_ok", 32'(ok_q[base]), 32'd1);
            check("patAA_data", 32'(rx_q[base + 1]), 32'hAA);
            check("patAA_ok", 32'(ok_q[base + 1]), 32'd1);
            check("pat_spacing", 32'(start_q[base + 1] - start_q[base]), 32'(FRAME));
        end
        wait_busy_low(t_busy);

        // Reset mid-DATA with 2 bytes queued
        push_one(8'h11, acc);
        push_one(8'h22, acc);
        push_one(8'h33, acc);
        repeat (1000) @(negedge clk);
        check("midrst_level_before", 32'(fifo_level), 32'd2);
        base = rx_q.size();
        rst_n = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("postrst_tx", 32'(tx), 32'd1);
        push_one(8'h3C, acc);
        wait_busy_low(t_busy);
        repeat (5) @(negedge clk);
        check("postrst_frames", 32'(rx_q.size()), 32'(base + 1));
        if (rx_q.size() > base) begin
            check("postrst_data", 32'(rx_q[base]), 32'h3C);
            check("postrst_ok", 32'(ok_q[base]), 32'd1);
            check("postrst_latency", 32'(start_q[base] - acc), 32'd1);
        end

        // Push during the last clock of a stop bit, FIFO empty
        base = rx_q.size();
        push_one(8'h81, acc);
        for (int i = 0; i < 5000 && cyc < acc + FRAME; i++) @(negedge clk);
        push_one(8'h42, acc2);
        check("stoppush_accept_edge", 32'(acc2 - acc), 32'(FRAME + 1));
        check("stoppush_tx_high", 32'(tx), 32'd1);
        check("stoppush_level", 32'(fifo_level), 32'd1);
        wait_busy_low(t_busy);
        repeat (5) @(negedge clk);
        check("stoppush_frames", 32'(rx_q.size()), 32'(base + 2));
        if (rx_q.size() >= base + 2) begin
            check("stoppush_data0", 32'(rx_q[base]), 32'h81);
            check("stoppush_ok0", 32'(ok_q[base]), 32'd1);
            check("stoppush_data1", 32'(rx_q[base + 1]), 32'h42);
            check("stoppush_ok1", 32'(ok_q[base + 1]), 32'd1);
            check("stoppush_latency", 32'(start_q[base + 1] - acc2), 32'd1);
            check("stoppush_spacing", 32'(start_q[base + 1] - start_q[base]), 32'(FRAME + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
